// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encodings and 100 MHz default timing for the WS2812 frame transmitter
package ws2812_pkg;
  typedef enum logic [2:0] {T_IDLE, T_WAIT, T_HIGH, T_LOW, T_LATCH} tx_state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_GAP} fetch_state_t;
  localparam int T0H_DEF  = 40;
  localparam int T1H_DEF  = 80;
  localparam int TBIT_DEF = 125;
  localparam int TRST_DEF = 8000;
endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: shapes one WS2812 bit period (high phase then low phase) per go pulse
module ws2812_bit_timer import ws2812_pkg::*; #(
  parameter int T0H_CYC  = T0H_DEF,
  parameter int T1H_CYC  = T1H_DEF,
  parameter int TBIT_CYC = TBIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_i,
  input  logic bit_i,
  output logic ctrl_o,
  output logic bit_done_o
);
  localparam int CW = $clog2(TBIT_CYC);
  logic          active_q;
  logic          bit_q;
  logic [CW-1:0] cnt_q;
  // go restarts the period even in the cycle the previous one ends, keeping bits back-to-back
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      active_q <= 1'b0;
      bit_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (go_i) begin
      active_q <= 1'b1;
      bit_q    <= bit_i;
      cnt_q    <= '0;
    end else if (active_q) begin
      active_q <= !bit_done_o;
      cnt_q    <= cnt_q + CW'(1);
    end
  assign ctrl_o     = active_q && (cnt_q < (bit_q ? CW'(T1H_CYC) : CW'(T0H_CYC)));
  assign bit_done_o = active_q && (cnt_q == CW'(TBIT_CYC - 1));
endmodule

// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx: fetches N_LEDS colours via start/done and streams them as WS2812 frames
module ws2812_frame_tx import ws2812_pkg::*; #(
  parameter int N_LEDS       = 64,
  parameter int W_ADDR       = 6,
  parameter int W_DATA       = 24,
  parameter int T0H_CYC      = T0H_DEF,
  parameter int T1H_CYC      = T1H_DEF,
  parameter int TBIT_CYC     = TBIT_DEF,
  parameter int TRST_CYC     = TRST_DEF,
  parameter int FETCH_TO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              data_start,
  output logic [W_ADDR-1:0] data_addr,
  input  logic              data_done,
  input  logic [W_DATA-1:0] data_color,
  output logic              ctrl,
  output logic              busy,
  output logic              frame_done,
  output logic              fetch_err
);
  localparam int AW = W_ADDR + 1;
  localparam int BW = $clog2(W_DATA);
  localparam int LW = $clog2(TRST_CYC + 1);
  localparam int OW = $clog2(FETCH_TO_CYC + 1);
  tx_state_t    tx_q, tx_d;
  fetch_state_t f_q, f_d;
  logic [W_DATA-1:0] buf_q, buf_d, sh_q, sh_d;
  logic              buf_v_q, buf_v_d, err_q, err_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [AW-1:0]     pix_q, pix_d, addr_q, addr_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [OW-1:0]     to_q, to_d;
  logic              go, load, bit_done, active;
  ws2812_bit_timer #(.T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .TBIT_CYC(TBIT_CYC)) u_timer (
    .clk(clk), .rst_n(rst_n), .go_i(go), .bit_i(sh_d[W_DATA-1]), .ctrl_o(ctrl), .bit_done_o(bit_done)
  );
  assign active     = (tx_q == T_WAIT) || (tx_q == T_HIGH) || (tx_q == T_LOW);
  assign data_start = (f_q == F_REQ);
  assign data_addr  = addr_q[W_ADDR-1:0];
  assign busy       = (tx_q != T_IDLE);
  assign frame_done = (tx_q == T_LATCH) && (lat_q == LW'(TRST_CYC - 1));
  assign fetch_err  = err_q;
  // next state for both FSMs; a pixel is taken straight from the buffer at the end of a pixel to avoid a gap
  always_comb begin
    tx_d = tx_q; f_d = f_q; buf_d = buf_q; buf_v_d = buf_v_q; sh_d = sh_q; err_d = err_q;
    bit_cnt_d = bit_cnt_q; pix_d = pix_q; addr_d = addr_q; lat_d = lat_q; to_d = to_q;
    go = 1'b0; load = 1'b0;
    case (tx_q)
      T_IDLE: if (en) begin
        tx_d = T_WAIT; addr_d = '0; pix_d = '0; buf_v_d = 1'b0;
      end
      T_WAIT: load = buf_v_q;
      T_HIGH, T_LOW: begin
        if (tx_q == T_HIGH && !ctrl) tx_d = T_LOW;
        if (bit_done) begin
          if (bit_cnt_q != '0) begin
            go = 1'b1; bit_cnt_d = bit_cnt_q - BW'(1); sh_d = sh_q << 1; tx_d = T_HIGH;
          end else if (pix_q < AW'(N_LEDS)) begin
            load = buf_v_q; tx_d = T_WAIT;
          end else begin
            tx_d = T_LATCH; lat_d = '0;
          end
        end
      end
      T_LATCH: if (lat_q == LW'(TRST_CYC - 1)) begin
        lat_d = '0; tx_d = en ? T_WAIT : T_IDLE;
        if (en) begin addr_d = '0; pix_d = '0; buf_v_d = 1'b0; end
      end else lat_d = lat_q + LW'(1);
      default: tx_d = T_IDLE;
    endcase
    if (load) begin
      sh_d = buf_q; buf_v_d = 1'b0; bit_cnt_d = BW'(W_DATA - 1); pix_d = pix_q + AW'(1); go = 1'b1; tx_d = T_HIGH;
    end
    case (f_q)
      F_IDLE: if (!buf_v_q && active && addr_q < AW'(N_LEDS)) begin f_d = F_REQ; to_d = '0; end
      F_REQ: if (data_done) begin
        buf_d = data_color; buf_v_d = 1'b1; f_d = F_GAP;
      end else if (to_q == OW'(FETCH_TO_CYC - 1)) begin
        buf_d = '0; buf_v_d = 1'b1; err_d = 1'b1; f_d = F_GAP;
      end else to_d = to_q + OW'(1);
      F_GAP: begin addr_d = addr_q + AW'(1); f_d = F_IDLE; end
      default: f_d = F_IDLE;
    endcase
  end
  // state registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_q <= T_IDLE; f_q <= F_IDLE; buf_q <= '0; buf_v_q <= 1'b0; sh_q <= '0; err_q <= 1'b0;
      bit_cnt_q <= '0; pix_q <= '0; addr_q <= '0; lat_q <= '0; to_q <= '0;
    end else begin
      tx_q <= tx_d; f_q <= f_d; buf_q <= buf_d; buf_v_q <= buf_v_d; sh_q <= sh_d; err_q <= err_d;
      bit_cnt_q <= bit_cnt_d; pix_q <= pix_d; addr_q <= addr_d; lat_q <= lat_d; to_q <= to_d;
    end
endmodule

// File: tb/tb_ws2812_frame_tx.sv
// tb_ws2812_frame_tx: frame-level checks of pulse widths, bit periods, latch gap, fetch flow and reset
module tb_ws2812_frame_tx;
  localparam int N = 2, T0H = 40, T1H = 80, TBIT = 125, TRST = 8000;
  logic clk = 0, rst_n = 0, en = 0, data_done = 0;
  logic [23:0] data_color = 0;
  logic data_start, ctrl, busy, frame_done, fetch_err;
  logic [0:0] data_addr;
  ws2812_frame_tx #(.N_LEDS(N), .W_ADDR(1), .W_DATA(24), .T0H_CYC(T0H), .T1H_CYC(T1H),
    .TBIT_CYC(TBIT), .TRST_CYC(TRST), .FETCH_TO_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .data_start(data_start), .data_addr(data_addr),
    .data_done(data_done), .data_color(data_color), .ctrl(ctrl), .busy(busy),
    .frame_done(frame_done), .fetch_err(fetch_err));
  always #5 clk = ~clk;

  typedef struct { logic [23:0] c0; logic [23:0] c1; bit sup; bit exp_err; } vec_t;
  vec_t vecs[3];
  int checks = 0, errors = 0;
  logic [23:0] mem [N];
  int suppress = -1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // colour source model: done two cycles after each start rise, random stray done pulses otherwise
  int fetch_idx = 0, req_cnt = 0, addr_bad = 0, stab_bad = 0, src_cnt = 0, paddr = 0;
  bit pend = 0, ds_prev = 0;
  initial forever begin
    @(posedge clk); #1;
    data_done = 0;
    if (!rst_n) begin pend = 0; ds_prev = 0; fetch_idx = 0; end
    else begin
      if (data_start && !ds_prev) begin
        req_cnt++; paddr = int'(data_addr);
        if (paddr != fetch_idx % N) addr_bad++;
        fetch_idx++; pend = (paddr != suppress); src_cnt = 2;
      end else if (pend) begin
        src_cnt--;
        if (src_cnt == 0) begin data_done = 1; data_color = mem[paddr]; pend = 0; end
      end else if (!data_start && $urandom_range(0, 40) == 0) begin
        data_done = 1; data_color = 24'($urandom);
      end
      if (data_start && int'(data_addr) != paddr) stab_bad++;
      ds_prev = data_start;
    end
  end

  // line monitor: high widths and rise times per frame, snapshotted at frame_done
  int cyc = 0, hi_run = 0, nframes = 0, fd_cyc = 0;
  bit pc = 0;
  int hq[$], rq[$], fhq[$], frq[$];
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    if (!rst_n) begin hq.delete(); rq.delete(); hi_run = 0; pc = 0; end
    else begin
      if (ctrl) hi_run++;
      else if (pc) begin hq.push_back(hi_run); hi_run = 0; end
      if (ctrl && !pc) rq.push_back(cyc);
      if (frame_done) begin fhq = hq; frq = rq; hq.delete(); rq.delete(); fd_cyc = cyc; nframes++; end
      pc = ctrl;
    end
  end

  task automatic do_reset();
    rst_n = 0; en = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctrl", ctrl, 0); chk("rst_start", data_start, 0); chk("rst_addr", data_addr, 0);
    chk("rst_busy", busy, 0); chk("rst_frame_done", frame_done, 0); chk("rst_fetch_err", fetch_err, 0);
    rst_n = 1;
  endtask

  task automatic wait_frame();
    int n0 = nframes;
    for (int k = 0; k < 20000 && nframes == n0; k++) begin @(posedge clk); #2; end
    chk("frame_done_seen", nframes != n0, 1);
  endtask

  task automatic check_frame(input logic [47:0] w, input bit exp_err);
    chk("bit_count", fhq.size(), 48);
    for (int i = 0; i < fhq.size() && i < 48; i++)
      chk($sformatf("bit%0d_high", i), fhq[i], w[47-i] ? T1H : T0H);
    for (int i = 1; i < frq.size(); i++) chk($sformatf("bit%0d_period", i), frq[i] - frq[i-1], TBIT);
    if (frq.size() > 0) chk("latch_gap", fd_cyc - frq[frq.size()-1], TBIT - 1 + TRST);
    chk("fetch_err", fetch_err, exp_err);
  endtask

  task automatic check_idle();
    int r1;
    @(posedge clk); #2;
    chk("busy_after", busy, 0); chk("frame_done_pulse", frame_done, 0);
    r1 = req_cnt;
    repeat (50) @(posedge clk);
    #2;
    chk("idle_no_start", req_cnt - r1, 0); chk("idle_busy", busy, 0); chk("idle_ctrl", ctrl, 0);
  endtask

  initial begin
    int en_cyc, r0, ab0, sb0, f1, seen;
    vecs[0] = '{24'hF00000, 24'h000001, 1'b0, 1'b0};
    vecs[1] = '{24'($urandom), 24'($urandom), 1'b0, 1'b0};
    vecs[2] = '{24'($urandom), 24'($urandom), 1'b1, 1'b1};
    do_reset();
    @(posedge clk); #2; en = 1; seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin @(posedge clk); #2; seen = data_start; end
    chk("wait_start", seen, 1);
    #3 rst_n = 0;
    #1 chk("async_rst_start", data_start, 0); chk("async_rst_ctrl0", ctrl, 0);
    en = 0; #1 rst_n = 1;
    @(posedge clk); #2; en = 1; seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin @(posedge clk); #2; seen = ctrl; end
    chk("wait_ctrl", seen, 1);
    #1 rst_n = 0;
    #1 chk("async_rst_ctrl", ctrl, 0); chk("async_rst_start2", data_start, 0); chk("async_rst_busy", busy, 0);
    en = 0; #1 rst_n = 1;
    foreach (vecs[v]) begin
      do_reset();
      mem[0] = vecs[v].c0; mem[1] = vecs[v].c1; suppress = vecs[v].sup ? 1 : -1;
      r0 = req_cnt; ab0 = addr_bad; sb0 = stab_bad;
      @(posedge clk); #2; en = 1; en_cyc = cyc;
      repeat (10) @(posedge clk);
      #2; en = 0;
      wait_frame();
      check_frame({vecs[v].c0, vecs[v].sup ? 24'h0 : vecs[v].c1}, vecs[v].exp_err);
      if (frq.size() > 0) chk("first_rise_latency_ge4", (frq[0] - en_cyc) >= 4, 1);
      chk("req_count", req_cnt - r0, N); chk("addr_seq", addr_bad - ab0, 0); chk("addr_stable", stab_bad - sb0, 0);
      check_idle();
    end
    do_reset();
    mem[0] = 24'($urandom); mem[1] = 24'($urandom); suppress = -1;
    ab0 = addr_bad; sb0 = stab_bad;
    @(posedge clk); #2; en = 1;
    wait_frame();
    f1 = fd_cyc;
    check_frame({mem[0], mem[1]}, 1'b0);
    repeat (100) @(posedge clk);
    #2; en = 0;
    wait_frame();
    chk("b2b_period_in_range", (fd_cyc - f1) >= 2 * 24 * TBIT + TRST && (fd_cyc - f1) <= 2 * 24 * TBIT + TRST + 16, 1);
    check_frame({mem[0], mem[1]}, 1'b0);
    chk("b2b_addr_seq", addr_bad - ab0, 0); chk("b2b_addr_stable", stab_bad - sb0, 0);
    check_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
